sock_tx_arbiter: RTL
====================

Name: sock_tx_arbiter

Overview:
- Round-robin packet arbiter that shares the single socket transmit channel (the socket_din / socket_din_valid / socket_din_ready input of socket_server_wrapper) between N_REQ on-FPGA requester streams.
- Each requester presents packets of one or more beats, delimited by a last flag.
- The arbiter locks onto one requester for a whole packet and tags every output beat with the source index.
- Output is registered, so it drives the socket channel directly.

Parameters:
- N_REQ, 4, number of requester ports; legal range 2..16.
- DWIDTH, 64, data width of each beat; equals the socket channel width (DWIDTH_IN of the wrapper).
- IDW, $clog2(N_REQ), width of the source-id tag (derived; not overridable).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- req_data  in  N_REQ*DWIDTH  packed beat data; requester i occupies bits [i*DWIDTH +: DWIDTH].
- req_valid  in  N_REQ  per-requester beat valid.
- req_last  in  N_REQ  per-requester last beat of packet; qualified by req_valid.
- req_ready  out  N_REQ  per-requester accept.
- out_data  out  DWIDTH  beat to the socket (to socket_din).
- out_id  out  IDW  source index of out_data.
- out_last  out  1  last beat of the current packet.
- out_valid  out  1  to socket_din_valid.
- out_ready  in  1  from socket_din_ready.

Behaviour:
- Handshakes:
  - Input transfer on requester i occurs when req_valid[i] && req_ready[i].
  - Output transfer occurs when out_valid && out_ready.
  - Once req_valid is asserted, a requester must hold its data and last stable until accepted. The arbiter does not check this.
- load_ok = !out_valid || out_ready.
  - The output register loads on any input transfer.
  - out_valid clears on an output transfer with no simultaneous load.
- Latency: exactly 1 cycle from input transfer to the beat appearing on out_*. Full throughput of 1 beat/cycle when out_ready is held high.
- State machine, 2 states:
  - IDLE:
    - grant = first i with req_valid[i], searching ptr, ptr+1, ... with modulo-N_REQ wrap.
    - req_ready[grant] = load_ok; all other req_ready bits are 0. If no req_valid is high, all req_ready bits are 0.
    - On a transfer with req_last=0: owner <= grant, go to LOCKED.
    - On a transfer with req_last=1: stay in IDLE and set ptr <= grant+1 (mod N_REQ).
  - LOCKED:
    - req_ready[owner] = load_ok; all others 0.
    - Other requesters' valids are ignored for the whole packet.
    - On a transfer with req_last=1: ptr <= owner+1 (mod N_REQ), go to IDLE.
- req_ready is combinational from req_valid, state, ptr, out_valid and out_ready. There is no combinational path from req_data to any output.
- ptr wrap: for N_REQ not a power of two, owner=N_REQ-1 gives ptr=0. ptr never holds a value >= N_REQ.
- Fairness: a requester with continuous valid is granted within N_REQ-1 packets.
- Backpressure:
  - With out_ready low and out_valid high, the output holds out_data, out_id and out_last unchanged.
  - All req_ready bits are 0.
  - state and ptr are frozen.
- Simultaneous events: an output transfer and a new load in the same cycle keep out_valid=1 and replace the register contents (no bubble).
- Reset:
  - Values: out_valid=0, out_last=0, out_id=0, out_data=0, state=IDLE, ptr=0, owner=0.
  - While rst is high, req_ready is 0.
  - Reset mid-packet abandons the packet; the downstream sees no further beats of it. Requesters are also reset by rst and must not resume the packet.
- No buffering beyond the single output register. No packet-length limit.

Decomposition:
- Package sock_arb_pkg holds:
  - the state enum typedef (ARB_IDLE, ARB_LOCKED);
  - a function rr_pick(valid, ptr) that returns {found, index}, shared with the future receive-side demux.
- One sub-module, sock_out_reg: the valid/ready output register holding {data, id, last}. It is reusable as the stage in front of socket_server_wrapper elsewhere.

Test Plan:
- Requester 0 only, 3-beat packet 0xA0, 0xA1, 0xA2 with last on 0xA2, out_ready=1 → out_data A0/A1/A2 on consecutive cycles, 1 cycle after each input transfer; out_id=0; out_last only on A2; ptr becomes 1.
- All four requesters valid with single-beat packets 0x10*i, held continuously → out_id sequence 0,1,2,3,0,1 and out_data 0x00, 0x10, 0x20, 0x30, 0x00, ...; one beat per cycle.
- Requester 1 sends a 4-beat packet while requester 2 is valid from cycle 1 → all 4 beats of id=1 are output first; req_ready[2]=0 throughout; id=2 follows on the next cycle.
- out_ready held low for 5 cycles with out_valid=1 → out_data, out_id and out_last are stable; req_ready=0; on release, the held beat and the next beat transfer on back-to-back cycles.
- N_REQ=3, requester 2 sends a single beat, then requesters 0 and 2 are both valid → requester 0 is granted next (ptr wrapped to 0).
- rst asserted after beat 2 of a 4-beat packet from requester 3 → next cycle out_valid=0 and ptr=0; after release, a single beat from requester 1 is output with out_id=1 and out_last=1.

Source files
------------

// File: rtl/sock_arb_pkg.sv
// Shared types and helpers for the socket transmit arbiter and the future receive-side demux.
package sock_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Round-robin search over up to 16 requesters starting at ptr; returns {found, index}.
    // ptr must be below n, so ptr+k stays below 2n and a single subtraction wraps it.
    function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                           input logic [3:0]  ptr,
                                           input logic [4:0]  n);
        logic       found;
        logic [3:0] idx;
        logic [4:0] cand;
        found = 1'b0;
        idx   = 4'd0;
        for (int k = 0; k < 16; k++) begin
            cand = {1'b0, ptr} + 5'(k);
            if (cand >= n) begin
                cand = cand - n;
            end else begin
                cand = cand;
            end
            if (!found && (5'(k) < n) && valid[cand[3:0]]) begin
                found = 1'b1;
                idx   = cand[3:0];
            end else begin
                found = found;
            end
        end
        return {found, idx};
    endfunction

endpackage

// File: rtl/sock_out_reg.sv
// Single valid/ready output register holding {data, id, last}; usable as the stage in front of the socket.
module sock_out_reg #(
    parameter int DWIDTH = 64,
    parameter int IDW    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DWIDTH-1:0] in_data,
    input  logic [IDW-1:0]    in_id,
    input  logic              in_last,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [IDW-1:0]    out_id,
    output logic              out_last,
    output logic              out_valid
);

    logic [DWIDTH-1:0] data_r;
    logic [IDW-1:0]    id_r;
    logic              last_r;
    logic              valid_r;

    // Output register: load replaces contents, otherwise a consumed beat drops valid and contents hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r  <= '0;
            id_r    <= '0;
            last_r  <= 1'b0;
            valid_r <= 1'b0;
        end else if (load) begin
            data_r  <= in_data;
            id_r    <= in_id;
            last_r  <= in_last;
            valid_r <= 1'b1;
        end else if (out_ready) begin
            valid_r <= 1'b0;
        end
    end

    assign out_data  = data_r;
    assign out_id    = id_r;
    assign out_last  = last_r;
    assign out_valid = valid_r;

endmodule

// File: rtl/sock_tx_arbiter.sv
// Round-robin packet arbiter sharing the socket transmit channel between N_REQ requester streams.
module sock_tx_arbiter
    import sock_arb_pkg::*;
#(
    parameter  int N_REQ  = 4,
    parameter  int DWIDTH = 64,
    localparam int IDW    = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ*DWIDTH-1:0] req_data,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic [DWIDTH-1:0]       out_data,
    output logic [IDW-1:0]          out_id,
    output logic                    out_last,
    output logic                    out_valid,
    input  logic                    out_ready
);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [IDW-1:0]    ptr_r;
    logic [IDW-1:0]    ptr_nxt_s;
    logic [IDW-1:0]    owner_r;
    logic [IDW-1:0]    owner_nxt_s;
    logic [4:0]        pick_s;
    logic              found_s;
    logic [IDW-1:0]    grant_s;
    logic [IDW-1:0]    sel_s;
    logic [IDW-1:0]    sel_inc_s;
    logic [N_REQ-1:0]  req_ready_s;
    logic              load_ok_s;
    logic              xfer_s;
    logic              sel_last_s;
    logic [DWIDTH-1:0] sel_data_s;

    assign pick_s    = rr_pick(16'(req_valid), 4'(ptr_r), 5'(N_REQ));
    assign found_s   = pick_s[4];
    assign grant_s   = pick_s[IDW-1:0];
    assign load_ok_s = !out_valid || out_ready;

    assign sel_s      = (state_r == ARB_LOCKED) ? owner_r : grant_s;
    assign sel_inc_s  = (sel_s == IDW'(N_REQ-1)) ? '0 : sel_s + IDW'(1);
    assign sel_last_s = req_last[sel_s];
    assign sel_data_s = req_data[sel_s*DWIDTH +: DWIDTH];
    assign xfer_s     = |(req_valid & req_ready_s);
    assign req_ready  = req_ready_s;

    // Ready goes only to the selected requester, and only when the output register can take a beat.
    always_comb begin
        req_ready_s = '0;
        case (state_r)
            ARB_IDLE: begin
                if (found_s && load_ok_s && !rst) begin
                    req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << grant_s;
                end else begin
                    req_ready_s = '0;
                end
            end
            ARB_LOCKED: begin
                if (load_ok_s && !rst) begin
                    req_ready_s = {{(N_REQ-1){1'b0}}, 1'b1} << owner_r;
                end else begin
                    req_ready_s = '0;
                end
            end
            default: req_ready_s = '0;
        endcase
    end

    // Next-state: a non-last beat locks onto its source, a last beat moves the pointer past it.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        owner_nxt_s = owner_r;
        case (state_r)
            ARB_IDLE: begin
                if (xfer_s && sel_last_s) begin
                    ptr_nxt_s = sel_inc_s;
                end else if (xfer_s) begin
                    owner_nxt_s = grant_s;
                    state_nxt_s = ARB_LOCKED;
                end else begin
                    state_nxt_s = ARB_IDLE;
                end
            end
            ARB_LOCKED: begin
                if (xfer_s && sel_last_s) begin
                    ptr_nxt_s   = sel_inc_s;
                    state_nxt_s = ARB_IDLE;
                end else begin
                    state_nxt_s = ARB_LOCKED;
                end
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ARB_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            owner_r <= owner_nxt_s;
        end
    end

    sock_out_reg #(
        .DWIDTH (DWIDTH),
        .IDW    (IDW)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (xfer_s),
        .in_data   (sel_data_s),
        .in_id     (sel_s),
        .in_last   (sel_last_s),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .out_valid (out_valid)
    );

endmodule
